sample_serializer: RTL
======================

Name: sample_serializer

Overview:
- Parametrised successor to the fixed 32:1 sample selector.
- Captures a full frame of N_SAMPLES parallel samples (e.g. an FFT output stage) in one cycle, then streams them one per beat over a valid/ready interface.
- Stream order is natural or bit-reversed, chosen per frame.
- Sits between the parallel FFT core and any serial consumer (UART/DAC/FIFO); removes the need for an external counter driving a wide mux select.

Parameters:
- DATA_LENGTH, 8, width of one sample in bits.
- N_SAMPLES, 32, samples per frame; power of two, >= 2.
- SEL_W (localparam), $clog2(N_SAMPLES), index/counter width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_SAMPLES*DATA_LENGTH  flat frame; sample k at [k*DATA_LENGTH +: DATA_LENGTH].
- in_valid  in  1  frame on in_data is valid.
- in_ready  out  1  block will capture the frame this cycle if in_valid.
- bitrev_mode  in  1  sampled with the frame: 0 = natural order, 1 = bit-reversed order.
- out_data  out  DATA_LENGTH  current sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_index  out  SEL_W  source index k of the sample on out_data.
- out_last  out  1  final beat of the frame.
- busy  out  1  frame held, not yet fully drained (equals out_valid).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Storage: frame buffer register, N_SAMPLES x DATA_LENGTH; mode register; beat counter cnt[SEL_W-1:0]; state register.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - STREAM: out_valid=1.
- Capture: in_valid && in_ready at edge -> buffer <= in_data, mode <= bitrev_mode, cnt <= 0, state <= STREAM.
- Latency: first beat is valid on the cycle after capture.
- Source index: src = mode ? bit_reverse(cnt) : cnt, where bit_reverse swaps bit i with bit SEL_W-1-i.
- Output drive:
  - out_data = buffer[src]; out_index = src.
  - Both are driven combinationally from registers and do not depend on any input in the same cycle.
- Beat transfer: out_valid && out_ready.
  - cnt not at N_SAMPLES-1: cnt increments.
  - Stalled (out_ready=0): out_data, out_index and out_last hold stable; no beat is skipped or repeated.
- out_last = out_valid && (cnt == N_SAMPLES-1).
- Last beat accepted:
  - with in_valid=0: state <= IDLE, cnt <= 0.
  - with in_valid=1: new frame captured in the same cycle; stay in STREAM with cnt <= 0. This gives zero-bubble back-to-back frames.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). The combinational path from out_ready to in_ready is intentional.
- Ignored inputs:
  - in_data and bitrev_mode changes during STREAM have no effect until the next capture.
  - in_valid during STREAM, other than on the last-beat cycle, is not captured; the producer must hold in_valid.
- Reset values: state IDLE, cnt 0, buffer all 0, mode 0. Outputs: out_valid 0, out_last 0, busy 0, in_ready 1, out_index 0, out_data 0.
- Reset mid-frame: the frame is discarded; the next capture restarts at cnt 0.
- Reset has priority over capture and transfer in the same cycle.
- N_SAMPLES=2: bit-reverse is the identity, so both modes give order 0,1.

Test Plan:
- Natural order: N_SAMPLES=8, DATA_LENGTH=8, sample k = 0x10+k, bitrev_mode=0, out_ready=1 -> out_data 0x10..0x17 on cycles 1..8 after capture; out_index 0..7; out_last only with 0x17; in_ready=1 on that cycle; out_valid=0 on cycle 9.
- Bit-reversed: same frame, bitrev_mode=1 -> out_index 0,4,2,6,1,5,3,7; out_data 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- Backpressure: out_ready pattern 1,0,0,1,0,1,... -> each of the 8 samples is delivered exactly once, in order; out_data and out_index are unchanged across stall cycles; total beats = 8.
- Back-to-back: frame A (0x10+k), then frame B (0x20+k) with in_valid held from cycle 2 -> B is captured on A's last beat; 0x20 appears the cycle after 0x17; 16 beats in 16 cycles; out_valid never drops.
- Input isolation and reset: change in_data to 0xFF and toggle bitrev_mode during STREAM -> output unchanged. Assert rst after 3 beats -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0. New frame 0x30+k then streams from 0x30.
- Default parameters: N_SAMPLES=32, random frames in both modes with random out_ready -> scoreboard match against the reference ordering (natural/bit-reversed, SEL_W=5); out_last on beat 32 only.

Source files
------------

// File: rtl/sample_serializer.sv
// Frame-at-once capture, one-sample-per-beat valid/ready streamer.
// Each frame is streamed in natural or bit-reversed index order, picked when the frame is captured.
module sample_serializer #(
  parameter  int DATA_LENGTH = 8,
  parameter  int N_SAMPLES   = 32,
  localparam int SEL_W       = $clog2(N_SAMPLES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_SAMPLES*DATA_LENGTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             bitrev_mode,
  output logic [DATA_LENGTH-1:0]           out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL_W-1:0]                 out_index,
  output logic                             out_last,
  output logic                             busy
);

  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(N_SAMPLES - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                                  state_q;
  logic [N_SAMPLES-1:0][DATA_LENGTH-1:0]   frame_q;
  logic                                    mode_q;
  logic [SEL_W-1:0]                        cnt_q;
  logic [SEL_W-1:0]                        cnt_rev;
  logic [SEL_W-1:0]                        src;
  logic                                    beat;
  logic                                    capture;

  for (genvar i = 0; i < SEL_W; i++) begin : g_rev
    assign cnt_rev[i] = cnt_q[SEL_W-1-i];
  end

  assign src       = mode_q ? cnt_rev : cnt_q;
  assign out_data  = frame_q[src];
  assign out_index = src;
  assign out_valid = (state_q == STREAM);
  assign busy      = out_valid;
  assign out_last  = out_valid && (cnt_q == LAST_CNT);
  assign beat      = out_valid && out_ready;
  // Ready on the final accepted beat lets the next frame land with no bubble.
  assign in_ready  = (state_q == IDLE) || (beat && out_last);
  assign capture   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (capture) begin
      state_q <= STREAM;
      frame_q <= in_data;
      mode_q  <= bitrev_mode;
      cnt_q   <= '0;
    end else if (beat) begin
      if (out_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + SEL_W'(1);
      end
    end
  end

endmodule
